// File: rtl/bcd_seq_converter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_seq_converter
// Description : Sequential binary-to-BCD converter. It performs one
//               double-dabble step per clock and produces N packed BCD digits
//               plus active-low 7-segment codes. Outputs are registered and
//               change only on the edge that raises done.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_seq_converter #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [7*DIGITS-1:0]   seg_out
);

  // 10**n computed at elaboration time; 64 bits covers 10**9 comfortably
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < n; k++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  // Active-low segment code, bit 6 = a ... bit 0 = g; non-decimal shows a dash
  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b1100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0001100;
      default: s = 7'b1111110;
    endcase
    return s;
  endfunction

  localparam int          BCD_W     = 4 * DIGITS;
  localparam int          SEG_W     = 7 * DIGITS;
  localparam int          SH_W      = BCD_W + BIN_W;
  localparam int          CNT_W     = $clog2(BIN_W + 1);
  localparam logic [63:0] OVF_LIMIT = pow10(DIGITS);
  localparam logic [6:0]  SEG_DASH  = 7'b1111110;
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_load;
  logic               w_step;
  logic               w_last;

  logic [SH_W-1:0]    r_sh;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_blank;
  logic               r_ovf_lat;
  logic               r_busy;
  logic               r_done;
  logic               r_ovf;
  logic [BCD_W-1:0]   r_bcd;
  logic [SEG_W-1:0]   r_seg;

  logic [SH_W-1:0]    w_adj;
  logic [SH_W-1:0]    w_shift;
  logic [BCD_W-1:0]   w_bcd_new;
  logic [SEG_W-1:0]   w_seg_new;
  logic               w_ovf_in;

  // Unsigned compare widened to 64 bits; false by construction when the
  // input range cannot reach 10**DIGITS
  assign w_ovf_in = ({{(64 - BIN_W){1'b0}}, bin_in} >= OVF_LIMIT);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and datapath controls
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = S_CONV;
        end
      end
      S_CONV: begin
        w_step = 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_last      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left
  always_comb begin
    w_adj = r_sh;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_sh[BIN_W + 4*i +: 4] >= 4'd5) begin
        w_adj[BIN_W + 4*i +: 4] = r_sh[BIN_W + 4*i +: 4] + 4'd3;
      end
    end
    w_shift = w_adj << 1;
  end

  assign w_bcd_new = w_shift[SH_W-1 -: BCD_W];

  // Segment encoding of the final BCD field, with overflow dashes and
  // leading-zero blanking scanned from the most significant digit down
  always_comb begin
    logic       w_zero_above;
    logic [3:0] w_dig;
    w_seg_new    = '1;
    w_zero_above = 1'b1;
    w_dig        = 4'd0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_dig = w_bcd_new[4*i +: 4];
      if (r_ovf_lat) begin
        w_seg_new[7*i +: 7] = SEG_DASH;
      end else if (r_blank && w_zero_above && (w_dig == 4'd0) && (i != 0)) begin
        w_seg_new[7*i +: 7] = SEG_BLANK;
      end else begin
        w_seg_new[7*i +: 7] = seg_enc(w_dig);
      end
      w_zero_above = w_zero_above && (w_dig == 4'd0);
    end
  end

  // Shift register, step counter, captured controls and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh      <= '0;
      r_cnt     <= '0;
      r_blank   <= 1'b0;
      r_ovf_lat <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ovf     <= 1'b0;
      r_bcd     <= '0;
      r_seg     <= '1;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_sh      <= {{BCD_W{1'b0}}, bin_in};
        r_cnt     <= CNT_W'(BIN_W);
        r_blank   <= blank_lz;
        r_ovf_lat <= w_ovf_in;
        r_busy    <= 1'b1;
      end else if (w_step) begin
        r_sh  <= w_shift;
        r_cnt <= r_cnt - CNT_W'(1);
        if (w_last) begin
          r_bcd  <= w_bcd_new;
          r_seg  <= w_seg_new;
          r_ovf  <= r_ovf_lat;
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign ovf     = r_ovf;
  assign bcd_out = r_bcd;
  assign seg_out = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_bcd_seq_converter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_seq_converter
// Description : Self-checking bench for bcd_seq_converter: a default-size
//               instance driven from a vector table plus corner sequences,
//               and a 2-digit/7-bit instance swept over its full input range.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_seq_converter;

  localparam int BW  = 14;
  localparam int DG  = 4;
  localparam int BW2 = 7;
  localparam int DG2 = 2;

  localparam logic [6:0] SEG0 = 7'b0000001;
  localparam logic [6:0] SEG1 = 7'b1001111;
  localparam logic [6:0] SEG2 = 7'b0010010;
  localparam logic [6:0] SEG3 = 7'b0000110;
  localparam logic [6:0] SEG4 = 7'b1001100;
  localparam logic [6:0] SEG5 = 7'b0100100;
  localparam logic [6:0] SEG6 = 7'b1100000;
  localparam logic [6:0] SEG7 = 7'b0001111;
  localparam logic [6:0] SEG8 = 7'b0000000;
  localparam logic [6:0] SEG9 = 7'b0001100;
  localparam logic [6:0] SEGB = 7'b1111111;
  localparam logic [6:0] SEGD = 7'b1111110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n;
  logic               start;
  logic [BW-1:0]      bin_in;
  logic               blank_lz;
  logic               busy;
  logic               done;
  logic               ovf;
  logic [4*DG-1:0]    bcd_out;
  logic [7*DG-1:0]    seg_out;

  logic               start2;
  logic [BW2-1:0]     bin2;
  logic               blank2;
  logic               busy2;
  logic               done2;
  logic               ovf2;
  logic [4*DG2-1:0]   bcd2;
  logic [7*DG2-1:0]   seg2;

  bcd_seq_converter #(.BIN_W(BW), .DIGITS(DG)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in), .blank_lz(blank_lz),
    .busy(busy), .done(done), .ovf(ovf), .bcd_out(bcd_out), .seg_out(seg_out)
  );

  bcd_seq_converter #(.BIN_W(BW2), .DIGITS(DG2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bin_in(bin2), .blank_lz(blank2),
    .busy(busy2), .done(done2), .ovf(ovf2), .bcd_out(bcd2), .seg_out(seg2)
  );

  typedef struct {
    logic [15:0] bcd;
    logic [27:0] seg;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [7:0]  bcd;
    logic [13:0] seg;
    logic        ovf;
  } exp2_t;

  typedef struct {
    int unsigned val;
    bit          blank;
    logic [15:0] bcd;
    logic [27:0] seg;
    bit          ovf;
  } vec_t;

  localparam int NV = 13;
  vec_t  vecs[NV];
  exp_t  q1[$];
  exp2_t q2[$];
  exp_t  m1_e;
  exp2_t m2_e;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] segof(input int d);
    logic [6:0] s;
    case (d)
      0: s = SEG0; 1: s = SEG1; 2: s = SEG2; 3: s = SEG3; 4: s = SEG4;
      5: s = SEG5; 6: s = SEG6; 7: s = SEG7; 8: s = SEG8; 9: s = SEG9;
      default: s = SEGD;
    endcase
    return s;
  endfunction

  // Reference for the 2-digit instance built from integer division
  function automatic exp2_t model2(input int v, input bit bl);
    exp2_t e;
    int    r, d0, d1;
    r  = v % 100;
    d0 = r % 10;
    d1 = r / 10;
    e.ovf = (v >= 100);
    e.bcd = {4'(d1), 4'(d0)};
    if (e.ovf) begin
      e.seg = {SEGD, SEGD};
    end else begin
      e.seg[6:0]  = segof(d0);
      e.seg[13:7] = (bl && d1 == 0) ? SEGB : segof(d1);
    end
    return e;
  endfunction

  // Scoreboard for the default instance: compare whenever done is seen
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q1.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL spurious_done: done=1 with no conversion outstanding (t=%0t)", $time);
      end else begin
        m1_e = q1.pop_front();
        check("bcd_out", 64'(bcd_out), 64'(m1_e.bcd));
        check("seg_out", 64'(seg_out), 64'(m1_e.seg));
        check("ovf", 64'(ovf), 64'(m1_e.ovf));
        check("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  // Scoreboard for the 2-digit instance
  always @(negedge clk) begin
    if (done2 === 1'b1) begin
      if (q2.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL spurious_done2: done=1 with no conversion outstanding (t=%0t)", $time);
      end else begin
        m2_e = q2.pop_front();
        check("bcd2", 64'(bcd2), 64'(m2_e.bcd));
        check("seg2", 64'(seg2), 64'(m2_e.seg));
        check("ovf2", 64'(ovf2), 64'(m2_e.ovf));
        check("busy2_at_done", 64'(busy2), 64'd0);
      end
    end
  end

  // Drive one start cycle (called at a negedge); inputs are scrambled afterwards
  task automatic start1(input int unsigned v, input bit bl, input exp_t e);
    start    = 1'b1;
    bin_in   = BW'(v);
    blank_lz = bl;
    q1.push_back(e);
    @(posedge clk);
    #1;
    start    = 1'b0;
    bin_in   = BW'($urandom);
    blank_lz = 1'($urandom);
  endtask

  task automatic wait_done1(output int cyc);
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL timeout_done1: no done within %0d cycles", cyc);
  endtask

  task automatic start2_t(input int v, input bit bl);
    start2 = 1'b1;
    bin2   = BW2'(v);
    blank2 = bl;
    q2.push_back(model2(v, bl));
    @(posedge clk);
    #1;
    start2 = 1'b0;
    bin2   = BW2'($urandom);
    blank2 = 1'($urandom);
  endtask

  task automatic wait_done2(output int cyc);
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done2 === 1'b1) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL timeout_done2: no done within %0d cycles", cyc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   cyc;

    vecs[0]  = '{9999,  1'b0, 16'h9999, {SEG9, SEG9, SEG9, SEG9}, 1'b0};
    vecs[1]  = '{42,    1'b1, 16'h0042, {SEGB, SEGB, SEG4, SEG2}, 1'b0};
    vecs[2]  = '{0,     1'b1, 16'h0000, {SEGB, SEGB, SEGB, SEG0}, 1'b0};
    vecs[3]  = '{12000, 1'b0, 16'h2000, {SEGD, SEGD, SEGD, SEGD}, 1'b1};
    vecs[4]  = '{1234,  1'b0, 16'h1234, {SEG1, SEG2, SEG3, SEG4}, 1'b0};
    vecs[5]  = '{5,     1'b0, 16'h0005, {SEG0, SEG0, SEG0, SEG5}, 1'b0};
    vecs[6]  = '{10000, 1'b0, 16'h0000, {SEGD, SEGD, SEGD, SEGD}, 1'b1};
    vecs[7]  = '{16383, 1'b1, 16'h6383, {SEGD, SEGD, SEGD, SEGD}, 1'b1};
    vecs[8]  = '{907,   1'b1, 16'h0907, {SEGB, SEG9, SEG0, SEG7}, 1'b0};
    vecs[9]  = '{8,     1'b1, 16'h0008, {SEGB, SEGB, SEGB, SEG8}, 1'b0};
    vecs[10] = '{60,    1'b0, 16'h0060, {SEG0, SEG0, SEG6, SEG0}, 1'b0};
    vecs[11] = '{0,     1'b0, 16'h0000, {SEG0, SEG0, SEG0, SEG0}, 1'b0};
    vecs[12] = '{1000,  1'b1, 16'h1000, {SEG1, SEG0, SEG0, SEG0}, 1'b0};

    rst_n    = 1'b0;
    start    = 1'b0;
    bin_in   = '0;
    blank_lz = 1'b0;
    start2   = 1'b0;
    bin2     = '0;
    blank2   = 1'b0;
    repeat (3) @(negedge clk);

    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_ovf", 64'(ovf), 64'd0);
    check("reset_bcd", 64'(bcd_out), 64'd0);
    check("reset_seg", 64'(seg_out), 64'h0FFF_FFFF);

    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors with one idle cycle between conversions
    for (int i = 0; i < NV; i++) begin
      e.bcd = vecs[i].bcd;
      e.seg = vecs[i].seg;
      e.ovf = vecs[i].ovf;
      start1(vecs[i].val, vecs[i].blank, e);
      check("busy_after_start", 64'(busy), 64'd1);
      wait_done1(cyc);
      check("latency", 64'(cyc), 64'(BW + 1));
      @(negedge clk);
      check("done_one_cycle", 64'(done), 64'd0);
    end

    // A start pulse while busy is ignored
    start1(9999, 1'b0, '{16'h9999, {SEG9, SEG9, SEG9, SEG9}, 1'b0});
    repeat (4) @(negedge clk);
    start  = 1'b1;
    bin_in = BW'(1);
    @(posedge clk);
    #1;
    start  = 1'b0;
    wait_done1(cyc);
    check("latency_ignored_start", 64'(cyc), 64'(BW + 1 - 4));
    @(negedge clk);
    check("no_queued_start", 64'(busy), 64'd0);

    // Back-to-back: start issued in the done cycle
    start1(9999, 1'b0, '{16'h9999, {SEG9, SEG9, SEG9, SEG9}, 1'b0});
    wait_done1(cyc);
    start1(1234, 1'b0, '{16'h1234, {SEG1, SEG2, SEG3, SEG4}, 1'b0});
    wait_done1(cyc);
    check("b2b_latency", 64'(cyc), 64'(BW + 1));

    // Overflowed result in place so the reset visibly clears every output
    start1(16383, 1'b0, '{16'h6383, {SEGD, SEGD, SEGD, SEGD}, 1'b1});
    wait_done1(cyc);
    @(negedge clk);
    start1(5678, 1'b0, '{16'h5678, {SEG5, SEG6, SEG7, SEG8}, 1'b0});
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_busy", 64'(busy), 64'd0);
    check("async_reset_done", 64'(done), 64'd0);
    check("async_reset_ovf", 64'(ovf), 64'd0);
    check("async_reset_bcd", 64'(bcd_out), 64'd0);
    check("async_reset_seg", 64'(seg_out), 64'h0FFF_FFFF);
    q1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_after_reset", 64'(busy), 64'd0);

    // Fresh conversion after reset release
    start1(42, 1'b1, '{16'h0042, {SEGB, SEGB, SEG4, SEG2}, 1'b0});
    wait_done1(cyc);
    check("latency_after_reset", 64'(cyc), 64'(BW + 1));
    @(negedge clk);

    // Full sweep on the 2-digit, 7-bit instance
    for (int v = 0; v < 128; v++) begin
      start2_t(v, 1'(v & 1));
      wait_done2(cyc);
      check("latency2", 64'(cyc), 64'(BW2 + 1));
      @(negedge clk);
    end

    check("q1_drained", 64'(q1.size()), 64'd0);
    check("q2_drained", 64'(q2.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
